pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central hazard/stall/flush controller for the RV32I 5-stage pipeline (IF-ID-EX-MEM-WB).
//  Keeps a scoreboard of in-flight destination registers and selects forwarding sources for the ID operands.
//  Generates per-pipeline-register enable/flush, load-use and no-forward stalls, and memory-wait freezes.
//  Applies branch redirect flushes with a parametrised resolve stage.
// PARAMETERS
//  REG_AW         5   register-address width; address 0 is hard-zero and never matches
//  RESOLVE_STAGE  1   stage that raises redirect: 1=EX, 2=MEM, 3=WB
//  FWD_EN         1   1: forward from EX/MEM/WB; 0: stall until producer has retired
//  CNT_W          32  stall-cycle counter width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  id_valid     in   1       ID holds a real instruction
//  id_rs1       in   REG_AW  ID source register 1
//  id_rs2       in   REG_AW  ID source register 2
//  id_use_rs1   in   1       instruction reads rs1
//  id_use_rs2   in   1       instruction reads rs2
//  id_rd        in   REG_AW  ID destination register
//  id_wr        in   1       instruction writes rd
//  id_load      in   1       instruction is a load
//  redirect     in   1       taken jump/branch at RESOLVE_STAGE
//  acki_n       in   1       imem ack, 0 = ready
//  mem_req      in   1       MEM stage accessing dmem
//  ackd_n       in   1       dmem ack, 0 = ready
//  pc_en        out  1       PC register load enable
//  pr_en        out  4       enable: [0]IF/ID [1]ID/EX [2]EX/MEM [3]MEM/WB
//  pr_flush     out  4       synchronous clear to bubble, same bit order
//  fwd_a        out  2       rs1 source: 0=RF 1=EX 2=MEM 3=WB
//  fwd_b        out  2       rs2 source, same encoding
//  stall_cnt    out  CNT_W   count of cycles with pc_en=0
//  state        out  2       0=RUN 1=IWAIT 2=DWAIT
// BEHAVIOUR
//  Reset: state=RUN; scoreboard entries invalid; pend_redir=0; stall_cnt=0.
//   With acki_n=ackd_n=0 the outputs are pc_en=1, pr_en=4'hF, pr_flush=0, fwd_a=fwd_b=0.
//  Scoreboard: entries EX/MEM/WB, each {v, rd, wr, load}.
//   Advances on pr_en; a bubble is written into EX when pr_flush[1] is set or ID is stalled.
//  Match: entry v&wr, rd!=0, rd==rs, use_rs set, id_valid set. The youngest match (EX>MEM>WB) sets fwd.
//  Load-use (FWD_EN=1): EX entry is a load and matches.
//   Action: pc_en=0, pr_en[0]=0, pr_flush[1]=1; exactly 1 cycle, then fwd=2.
//  FWD_EN=0: any match stalls the same way; fwd held at 0 until no match remains.
//  DWAIT: entered when mem_req & ackd_n; left on the first cycle with ackd_n=0.
//   Action: pc_en=0, pr_en=0, no flush, scoreboard frozen.
//  IWAIT: acki_n=1 and not DWAIT.
//   Action: pc_en=0, pr_en[0]=0, pr_flush[0]... bubble via pr_flush[1]; EX..WB advance.
//  Priority: DWAIT > redirect > load-use/IWAIT.
//  Redirect (not frozen): pr_flush[RESOLVE_STAGE:0]=1, pc_en=1.
//   Matching scoreboard entries are invalidated; ID-stage stall is ignored that cycle.
//  Redirect during DWAIT: latched in pend_redir, applied on the first unfrozen cycle, then cleared.
//   A new redirect in that same cycle merges with the pending one (single flush).
//  stall_cnt: +1 on every cycle with pc_en=0; saturates at all-ones.
//  Reset mid-operation clears state and scoreboard immediately (async); no pending flush survives.
//  All outputs except state/stall_cnt are combinational from inputs+registers; no added latency.
// STRUCTURE
//  rv_pipe_pkg: stage indices (PR_IFID=0..PR_MEMWB=3), FWD_RF/EX/MEM/WB, ST_RUN/IWAIT/DWAIT.
//  Sub-module hz_sb_entry: one scoreboard slot (enable, bubble, invalidate); instantiate 3x.
//  No other hierarchy; FSM, priority logic and counter sit in this module.
// TESTING
//  1 EX={v,rd=5,wr,!load}; ID reads rs1=5 -> fwd_a=1, no stall.
//    Next cycle (entry in MEM) -> fwd_a=2.
//  2 EX={rd=7,load}; ID reads rs2=7 -> one cycle with pc_en=0, pr_flush[1]=1; then fwd_b=2; stall_cnt=1.
//  3 EX/MEM/WB all rd=0 wr; ID rs1=0 -> fwd_a=0, no stall.
//    Repeat with FWD_EN=0, rd=3 in WB -> 1-cycle stall.
//  4 mem_req=1, ackd_n=1 for 3 cycles, redirect pulsed in cycle 2 ->
//    state=DWAIT, pr_en=0 for 3 cycles; then pr_flush=4'b0011 (RESOLVE_STAGE=1) on exit.
//  5 acki_n=1 for 2 cycles -> pc_en=0, IF/ID held, bubble in EX; state=IWAIT; stall_cnt +2.
//  6 Assert rst_n=0 mid-DWAIT with pend_redir=1 -> state=RUN, pr_flush=0, stall_cnt=0.
//    No flush after release.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared constants for the RV32I pipeline hazard controller: pipeline-register
// indices, forwarding-source codes, controller states and the redirect flush mask.
package rv_pipe_pkg;

    localparam int PR_IFID  = 0;
    localparam int PR_IDEX  = 1;
    localparam int PR_EXMEM = 2;
    localparam int PR_MEMWB = 3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2
    } hz_state_e;

    // A redirect resolved in stage N kills every younger pipeline register [N:0].
    function automatic logic [3:0] redir_flush_mask(input int resolve_stage);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i <= resolve_stage) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hz_sb_entry.sv
// One scoreboard slot tracking the destination register of an in-flight
// instruction, plus its match against the two ID-stage source operands.
module hz_sb_entry #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_bubble,
    input  logic              i_v,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_wr,
    input  logic              i_load,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic              i_use_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use_rs2,
    output logic              o_v,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_wr,
    output logic              o_load,
    output logic              o_hit1,
    output logic              o_hit2
);

    logic              r_v;
    logic [REG_AW-1:0] r_rd;
    logic              r_wr;
    logic              r_load;
    logic              w_producer;

    // A bubble also acts as the invalidate path for flushed stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= 1'b0;
            r_rd   <= '0;
            r_wr   <= 1'b0;
            r_load <= 1'b0;
        end else if (i_en) begin
            r_v    <= i_v & ~i_bubble;
            r_rd   <= i_rd;
            r_wr   <= i_wr;
            r_load <= i_load;
        end
    end

    assign w_producer = r_v & r_wr & (r_rd != '0) & i_id_valid;
    assign o_hit1     = w_producer & i_use_rs1 & (r_rd == i_rs1);
    assign o_hit2     = w_producer & i_use_rs2 & (r_rd == i_rs2);

    assign o_v    = r_v;
    assign o_rd   = r_rd;
    assign o_wr   = r_wr;
    assign o_load = r_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for a 5-stage RV32I pipeline: scoreboard
// driven forwarding, load-use/no-forward stalls, memory-wait freezes and redirects.
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int RESOLVE_STAGE = 1,
    parameter int FWD_EN        = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              redirect,
    input  logic              acki_n,
    input  logic              mem_req,
    input  logic              ackd_n,
    output logic              pc_en,
    output logic [3:0]        pr_en,
    output logic [3:0]        pr_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        state
);

    localparam logic [3:0] REDIR_MASK = redir_flush_mask(RESOLVE_STAGE);

    hz_state_e        r_state;
    hz_state_e        w_state_next;
    logic             r_pend_redir;
    logic [CNT_W-1:0] r_stall_cnt;

    // Slot 0 = EX, 1 = MEM, 2 = WB; each slot is fed from the one before it.
    logic              w_v      [3];
    logic [REG_AW-1:0] w_rd     [3];
    logic              w_wr     [3];
    logic              w_ld     [3];
    logic              w_src_v  [3];
    logic [REG_AW-1:0] w_src_rd [3];
    logic              w_src_wr [3];
    logic              w_src_ld [3];
    logic [2:0]        w_hit1;
    logic [2:0]        w_hit2;

    logic w_frozen;
    logic w_redir;
    logic w_hazard;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sb
            localparam int PR_IDX = (gi == 0) ? PR_IDEX : (gi == 1) ? PR_EXMEM : PR_MEMWB;
            if (gi == 0) begin : g_from_id
                assign w_src_v[gi]  = id_valid;
                assign w_src_rd[gi] = id_rd;
                assign w_src_wr[gi] = id_wr;
                assign w_src_ld[gi] = id_load;
            end else begin : g_from_prev
                assign w_src_v[gi]  = w_v[gi-1];
                assign w_src_rd[gi] = w_rd[gi-1];
                assign w_src_wr[gi] = w_wr[gi-1];
                assign w_src_ld[gi] = w_ld[gi-1];
            end
            hz_sb_entry #(
                .REG_AW (REG_AW)
            ) u_entry (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_en       (pr_en[PR_IDX]),
                .i_bubble   (pr_flush[PR_IDX]),
                .i_v        (w_src_v[gi]),
                .i_rd       (w_src_rd[gi]),
                .i_wr       (w_src_wr[gi]),
                .i_load     (w_src_ld[gi]),
                .i_id_valid (id_valid),
                .i_rs1      (id_rs1),
                .i_use_rs1  (id_use_rs1),
                .i_rs2      (id_rs2),
                .i_use_rs2  (id_use_rs2),
                .o_v        (w_v[gi]),
                .o_rd       (w_rd[gi]),
                .o_wr       (w_wr[gi]),
                .o_load     (w_ld[gi]),
                .o_hit1     (w_hit1[gi]),
                .o_hit2     (w_hit2[gi])
            );
        end

        if (FWD_EN != 0) begin : g_fwd
            assign w_hazard = w_ld[0] & (w_hit1[0] | w_hit2[0]);
            assign fwd_a = w_hit1[0] ? FWD_EX : w_hit1[1] ? FWD_MEM : w_hit1[2] ? FWD_WB : FWD_RF;
            assign fwd_b = w_hit2[0] ? FWD_EX : w_hit2[1] ? FWD_MEM : w_hit2[2] ? FWD_WB : FWD_RF;
        end else begin : g_nofwd
            assign w_hazard = |{w_hit1, w_hit2};
            assign fwd_a    = FWD_RF;
            assign fwd_b    = FWD_RF;
        end
    endgenerate

    // Once in DWAIT only the dmem ack releases the freeze.
    assign w_frozen = (r_state == ST_DWAIT) ? ackd_n : (mem_req & ackd_n);
    assign w_redir  = redirect | r_pend_redir;

    always_comb begin
        pc_en        = 1'b1;
        pr_en        = 4'hF;
        pr_flush     = 4'h0;
        w_state_next = ST_RUN;
        if (w_frozen) begin
            pc_en = 1'b0;
            pr_en = 4'h0;
        end else if (w_redir) begin
            pr_flush = REDIR_MASK;
        end else if (w_hazard | acki_n) begin
            pc_en             = 1'b0;
            pr_en[PR_IFID]    = 1'b0;
            pr_flush[PR_IDEX] = 1'b1;
        end
        if (w_frozen) begin
            w_state_next = ST_DWAIT;
        end else if (acki_n) begin
            w_state_next = ST_IWAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pend_redir <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pend_redir <= w_frozen & (r_pend_redir | redirect);
            if (!pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two parameterisations share one stimulus
// stream and are checked against directed expectations and a pipeline model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wr, id_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       redirect, acki_n, mem_req, ackd_n;

    logic        f_pc_en, s_pc_en;
    logic [3:0]  f_pr_en, s_pr_en, f_pr_flush, s_pr_flush;
    logic [1:0]  f_fwd_a, s_fwd_a, f_fwd_b, s_fwd_b, f_state, s_state;
    logic [31:0] f_stall_cnt;
    logic [3:0]  s_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .RESOLVE_STAGE(1), .FWD_EN(1), .CNT_W(32)) dut_f (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
        .id_load(id_load), .redirect(redirect), .acki_n(acki_n), .mem_req(mem_req),
        .ackd_n(ackd_n), .pc_en(f_pc_en), .pr_en(f_pr_en), .pr_flush(f_pr_flush),
        .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .stall_cnt(f_stall_cnt), .state(f_state));

    pipe_hazard_ctrl #(.REG_AW(5), .RESOLVE_STAGE(2), .FWD_EN(0), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
        .id_load(id_load), .redirect(redirect), .acki_n(acki_n), .mem_req(mem_req),
        .ackd_n(ackd_n), .pc_en(s_pc_en), .pr_en(s_pr_en), .pr_flush(s_pr_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .state(s_state));

    // Model: instance 0 forwards and resolves in EX, instance 1 never forwards,
    // resolves in MEM and has a 4-bit counter.
    localparam int          FE   [2] = '{1, 0};
    localparam int          RS   [2] = '{1, 2};
    localparam logic [31:0] CMAX [2] = '{32'hFFFF_FFFF, 32'd15};

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } inst_t;

    inst_t       m_pipe [2][3];
    inst_t       n_pipe [2][3];
    logic        m_dw [2], n_dw [2], m_pend [2], n_pend [2];
    logic [1:0]  m_st [2], n_st [2];
    logic [31:0] m_cnt [2], n_cnt [2];
    logic        e_pc [2];
    logic [3:0]  e_en [2], e_fl [2];
    logic [1:0]  e_fa [2], e_fb [2];

    logic        o_pc [2];
    logic [3:0]  o_en [2], o_fl [2];
    logic [1:0]  o_fa [2], o_fb [2], o_st [2];
    logic [31:0] o_cnt [2];
    assign o_pc[0] = f_pc_en;     assign o_pc[1] = s_pc_en;
    assign o_en[0] = f_pr_en;     assign o_en[1] = s_pr_en;
    assign o_fl[0] = f_pr_flush;  assign o_fl[1] = s_pr_flush;
    assign o_fa[0] = f_fwd_a;     assign o_fa[1] = s_fwd_a;
    assign o_fb[0] = f_fwd_b;     assign o_fb[1] = s_fwd_b;
    assign o_st[0] = f_state;     assign o_st[1] = s_state;
    assign o_cnt[0] = f_stall_cnt; assign o_cnt[1] = {28'd0, s_stall_cnt};

    function automatic logic reads(inst_t e, logic [4:0] rs, logic use_r);
        return id_valid && use_r && e.v && e.wr && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) m_pipe[k][i] = '0;
            m_dw[k] = 1'b0; m_pend[k] = 1'b0; m_st[k] = 2'd0; m_cnt[k] = 32'd0;
        end
    endtask

    task automatic predict();
        for (int k = 0; k < 2; k++) begin
            logic frz, rdr, haz;
            int   y1, y2;
            frz = m_dw[k] ? ackd_n : (mem_req && ackd_n);
            rdr = redirect || m_pend[k];
            y1 = -1; y2 = -1;
            for (int i = 2; i >= 0; i--) begin
                if (reads(m_pipe[k][i], id_rs1, id_use_rs1)) y1 = i;
                if (reads(m_pipe[k][i], id_rs2, id_use_rs2)) y2 = i;
            end
            if (FE[k] != 0) haz = m_pipe[k][0].ld && (y1 == 0 || y2 == 0);
            else            haz = (y1 >= 0) || (y2 >= 0);
            e_fa[k] = (FE[k] != 0 && y1 >= 0) ? 2'(y1 + 1) : 2'd0;
            e_fb[k] = (FE[k] != 0 && y2 >= 0) ? 2'(y2 + 1) : 2'd0;
            if (frz) begin
                e_pc[k] = 1'b0; e_en[k] = 4'h0; e_fl[k] = 4'h0;
            end else if (rdr) begin
                e_pc[k] = 1'b1; e_en[k] = 4'hF; e_fl[k] = 4'((1 << (RS[k] + 1)) - 1);
            end else if (haz || acki_n) begin
                e_pc[k] = 1'b0; e_en[k] = 4'b1110; e_fl[k] = 4'b0010;
            end else begin
                e_pc[k] = 1'b1; e_en[k] = 4'hF; e_fl[k] = 4'h0;
            end
            n_pipe[k] = m_pipe[k];
            if (e_en[k][3]) n_pipe[k][2] = e_fl[k][3] ? inst_t'(0) : m_pipe[k][1];
            if (e_en[k][2]) n_pipe[k][1] = e_fl[k][2] ? inst_t'(0) : m_pipe[k][0];
            if (e_en[k][1]) n_pipe[k][0] = e_fl[k][1] ? inst_t'(0) : inst_t'({id_valid, id_rd, id_wr, id_load});
            n_pend[k] = frz && (m_pend[k] || redirect);
            n_dw[k]   = frz;
            n_st[k]   = frz ? 2'd2 : (acki_n ? 2'd1 : 2'd0);
            n_cnt[k]  = (!e_pc[k] && m_cnt[k] != CMAX[k]) ? m_cnt[k] + 32'd1 : m_cnt[k];
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_pipe = n_pipe; m_dw = n_dw; m_pend = n_pend; m_st = n_st; m_cnt = n_cnt;
    endtask

    task automatic tick();
        predict();
        advance();
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_rs1 = 5'd0; id_use_rs1 = 1'b0; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
        id_rd = 5'd0; id_wr = 1'b0; id_load = 1'b0;
        redirect = 1'b0; acki_n = 1'b0; mem_req = 1'b0; ackd_n = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_wr = wr; id_load = ld;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (f_pc_en !== 1'b1) begin n_err++; $display("FAIL reset pc_en: got %0b want 1", f_pc_en); end
        n_vec++; if (f_pr_en !== 4'hF) begin n_err++; $display("FAIL reset pr_en: got %h want f", f_pr_en); end
        n_vec++; if (f_pr_flush !== 4'h0) begin n_err++; $display("FAIL reset pr_flush: got %h want 0", f_pr_flush); end
        n_vec++; if ({f_fwd_a, f_fwd_b} !== 4'h0) begin n_err++; $display("FAIL reset fwd: got %0d/%0d want 0/0", f_fwd_a, f_fwd_b); end
        n_vec++; if (f_state !== 2'd0) begin n_err++; $display("FAIL reset state: got %0d want 0", f_state); end
        n_vec++; if (f_stall_cnt !== 32'd0 || s_stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset stall_cnt: got %0d/%0d want 0/0", f_stall_cnt, s_stall_cnt); end
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_vec++; if (f_fwd_a !== 2'd1) begin n_err++; $display("FAIL fwd_ex fwd_a: got %0d want 1", f_fwd_a); end
        n_vec++; if (f_pc_en !== 1'b1) begin n_err++; $display("FAIL fwd_ex pc_en: got %0b want 1", f_pc_en); end
        n_vec++; if (s_pc_en !== 1'b0 || s_fwd_a !== 2'd0) begin n_err++; $display("FAIL nofwd_ex pc_en/fwd_a: got %0b/%0d want 0/0", s_pc_en, s_fwd_a); end
        tick();
        #1;
        n_vec++; if (f_fwd_a !== 2'd2) begin n_err++; $display("FAIL fwd_mem fwd_a: got %0d want 2", f_fwd_a); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        n_vec++; if (f_pc_en !== 1'b0) begin n_err++; $display("FAIL load_use pc_en: got %0b want 0", f_pc_en); end
        n_vec++; if (f_pr_en !== 4'b1110) begin n_err++; $display("FAIL load_use pr_en: got %b want 1110", f_pr_en); end
        n_vec++; if (f_pr_flush !== 4'b0010) begin n_err++; $display("FAIL load_use pr_flush: got %b want 0010", f_pr_flush); end
        tick();
        #1;
        n_vec++; if (f_pc_en !== 1'b1) begin n_err++; $display("FAIL load_use_after pc_en: got %0b want 1", f_pc_en); end
        n_vec++; if (f_fwd_b !== 2'd2) begin n_err++; $display("FAIL load_use_after fwd_b: got %0d want 2", f_fwd_b); end
        n_vec++; if (f_stall_cnt !== 32'd1) begin n_err++; $display("FAIL load_use stall_cnt: got %0d want 1", f_stall_cnt); end
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            tick();
        end
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        n_vec++; if ({f_fwd_a, f_fwd_b} !== 4'h0) begin n_err++; $display("FAIL x0 fwd: got %0d/%0d want 0/0", f_fwd_a, f_fwd_b); end
        n_vec++; if (f_pc_en !== 1'b1 || s_pc_en !== 1'b1) begin n_err++; $display("FAIL x0 pc_en: got %0b/%0b want 1/1", f_pc_en, s_pc_en); end
        tick();
    endtask

    task automatic test_nofwd_wb();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_idle();
        tick();
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        n_vec++; if (s_pc_en !== 1'b0 || s_pr_flush !== 4'b0010) begin n_err++; $display("FAIL nofwd_wb stall: got pc_en=%0b flush=%b want 0/0010", s_pc_en, s_pr_flush); end
        n_vec++; if (f_fwd_a !== 2'd3 || f_pc_en !== 1'b1) begin n_err++; $display("FAIL fwd_wb: got fwd_a=%0d pc_en=%0b want 3/1", f_fwd_a, f_pc_en); end
        tick();
        #1;
        n_vec++; if (s_pc_en !== 1'b1 || s_fwd_a !== 2'd0) begin n_err++; $display("FAIL nofwd_wb release: got pc_en=%0b fwd_a=%0d want 1/0", s_pc_en, s_fwd_a); end
        n_vec++; if (s_stall_cnt !== 4'd1) begin n_err++; $display("FAIL nofwd_wb stall_cnt: got %0d want 1", s_stall_cnt); end
        tick();
    endtask

    task automatic test_dwait();
        do_reset();
        mem_req = 1'b1;
        ackd_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect = (i == 1);
            #1;
            n_vec++; if (f_pr_en !== 4'h0 || f_pc_en !== 1'b0 || f_pr_flush !== 4'h0) begin n_err++; $display("FAIL dwait[%0d] freeze: got pr_en=%h pc_en=%0b flush=%h want 0/0/0", i, f_pr_en, f_pc_en, f_pr_flush); end
            tick();
            n_vec++; if (f_state !== 2'd2) begin n_err++; $display("FAIL dwait[%0d] state: got %0d want 2", i, f_state); end
        end
        mem_req  = 1'b0;
        ackd_n   = 1'b0;
        redirect = 1'b1;
        #1;
        n_vec++; if (f_pr_flush !== 4'b0011 || f_pc_en !== 1'b1) begin n_err++; $display("FAIL dwait_exit flush: got %b pc_en=%0b want 0011/1", f_pr_flush, f_pc_en); end
        n_vec++; if (s_pr_flush !== 4'b0111) begin n_err++; $display("FAIL dwait_exit flush_mem: got %b want 0111", s_pr_flush); end
        tick();
        redirect = 1'b0;
        #1;
        n_vec++; if (f_pr_flush !== 4'h0 || s_pr_flush !== 4'h0) begin n_err++; $display("FAIL dwait_merge flush: got %b/%b want 0000/0000", f_pr_flush, s_pr_flush); end
        n_vec++; if (f_state !== 2'd0) begin n_err++; $display("FAIL dwait_exit state: got %0d want 0", f_state); end
        tick();
    endtask

    task automatic test_iwait();
        do_reset();
        acki_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (f_pc_en !== 1'b0 || f_pr_en !== 4'b1110 || f_pr_flush !== 4'b0010) begin n_err++; $display("FAIL iwait[%0d]: got pc_en=%0b pr_en=%b flush=%b want 0/1110/0010", i, f_pc_en, f_pr_en, f_pr_flush); end
            tick();
            n_vec++; if (f_state !== 2'd1) begin n_err++; $display("FAIL iwait[%0d] state: got %0d want 1", i, f_state); end
        end
        acki_n = 1'b0;
        #1;
        n_vec++; if (f_stall_cnt !== 32'd2 || f_pc_en !== 1'b1) begin n_err++; $display("FAIL iwait_end: got cnt=%0d pc_en=%0b want 2/1", f_stall_cnt, f_pc_en); end
        tick();
        n_vec++; if (f_state !== 2'd0) begin n_err++; $display("FAIL iwait_end state: got %0d want 0", f_state); end
    endtask

    task automatic test_saturate();
        do_reset();
        acki_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        acki_n = 1'b0;
        n_vec++; if (s_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat cnt4: got %0d want 15", s_stall_cnt); end
        n_vec++; if (f_stall_cnt !== 32'd20) begin n_err++; $display("FAIL sat cnt32: got %0d want 20", f_stall_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_req = 1'b1;
        ackd_n  = 1'b1;
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (f_state !== 2'd0 || f_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid: got state=%0d cnt=%0d want 0/0", f_state, f_stall_cnt); end
        n_vec++; if (f_pr_flush !== 4'h0) begin n_err++; $display("FAIL rst_mid flush: got %b want 0000", f_pr_flush); end
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_vec++; if (f_pr_flush !== 4'h0 || s_pr_flush !== 4'h0 || f_pc_en !== 1'b1) begin n_err++; $display("FAIL rst_release: got flush=%b/%b pc_en=%0b want 0000/0000/1", f_pr_flush, s_pr_flush, f_pc_en); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            id_valid   = ($urandom % 4) != 0;
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom % 2);
            id_use_rs2 = 1'($urandom % 2);
            id_rd      = 5'($urandom_range(0, 7));
            id_wr      = ($urandom % 4) != 0;
            id_load    = ($urandom % 3) == 0;
            redirect   = ($urandom % 8) == 0;
            acki_n     = ($urandom % 6) == 0;
            mem_req    = ($urandom % 4) == 0;
            ackd_n     = 1'($urandom % 2);
            #1;
            predict();
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (o_pc[k] !== e_pc[k]) begin n_err++; $display("FAIL rand[%0d] i%0d pc_en: got %0b want %0b", c, k, o_pc[k], e_pc[k]); end
                n_vec++; if (o_en[k] !== e_en[k]) begin n_err++; $display("FAIL rand[%0d] i%0d pr_en: got %b want %b", c, k, o_en[k], e_en[k]); end
                n_vec++; if (o_fl[k] !== e_fl[k]) begin n_err++; $display("FAIL rand[%0d] i%0d pr_flush: got %b want %b", c, k, o_fl[k], e_fl[k]); end
                n_vec++; if (o_fa[k] !== e_fa[k]) begin n_err++; $display("FAIL rand[%0d] i%0d fwd_a: got %0d want %0d", c, k, o_fa[k], e_fa[k]); end
                n_vec++; if (o_fb[k] !== e_fb[k]) begin n_err++; $display("FAIL rand[%0d] i%0d fwd_b: got %0d want %0d", c, k, o_fb[k], e_fb[k]); end
            end
            advance();
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (o_st[k] !== m_st[k]) begin n_err++; $display("FAIL rand[%0d] i%0d state: got %0d want %0d", c, k, o_st[k], m_st[k]); end
                n_vec++; if (o_cnt[k] !== m_cnt[k]) begin n_err++; $display("FAIL rand[%0d] i%0d stall_cnt: got %0d want %0d", c, k, o_cnt[k], m_cnt[k]); end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_forward();
        test_load_use();
        test_zero_reg();
        test_nofwd_wb();
        test_dwait();
        test_iwait();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
